// File: rtl/axi_pkg.sv
// axi_pkg
// Shared AXI definitions for the SRAM responder: default channel widths,
// response and burst encodings, and the responder state encoding.
package axi_pkg;

  localparam int AXI_ID_W   = 8;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_SRAM = 3'd1,
    R_DATA = 3'd2,
    W_DATA = 3'd3,
    W_RESP = 3'd4
  } sram_slv_state_e;

endpackage

// File: rtl/sram_axi_slave.sv
// sram_axi_slave
// AXI4 responder in front of one 32-bit synchronous SRAM macro. Handles one
// transaction at a time (single beats and INCR bursts up to 16 beats), with
// byte strobes on writes.
//
// Ports:
//   ACLK, ARESETn              clock, asynchronous active-low reset
//   AW*/W*/B*                  AXI write address, data and response channels
//   AR*/R*                     AXI read address and data channels
//   CEB, WEB, BWEB             SRAM chip enable, write enable, bit write enable (all active-low)
//   A, DI, DO                  SRAM word address, write data, read data
//
// state  | meaning
// IDLE   | waiting for AW or AR; write wins a same-cycle tie
// R_SRAM | SRAM read cycle for the current beat
// R_DATA | read beat presented on R, held until RREADY
// W_DATA | accepting W beats, each written straight into the SRAM
// W_RESP | write response presented on B, held until BREADY
module sram_axi_slave
  import axi_pkg::*;
#(
  parameter int ID_W    = AXI_ID_W,
  parameter int ADDR_W  = AXI_ADDR_W,
  parameter int DATA_W  = AXI_DATA_W,
  parameter int SRAM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESETn,

  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,

  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,

  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,

  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,

  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,

  output logic                CEB,
  output logic                WEB,
  output logic [DATA_W-1:0]   BWEB,
  output logic [SRAM_AW-1:0]  A,
  output logic [DATA_W-1:0]   DI,
  input  logic [DATA_W-1:0]   DO
);

  sram_slv_state_e      state;
  logic                 init_done;
  logic [ID_W-1:0]      id_q;
  logic [3:0]           len_q;
  logic [3:0]           cnt_q;
  logic [SRAM_AW-1:0]   addr_q;
  logic                 err_q;

  logic last_beat;
  logic aw_hs;
  logic ar_hs;
  logic w_hs;
  logic r_hs;
  logic b_hs;

  // Burst type, size and out-of-range address bits have no effect here.
  logic unused_inputs;
  assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST,
                           AWADDR[ADDR_W-1:SRAM_AW+2], AWADDR[1:0],
                           ARADDR[ADDR_W-1:SRAM_AW+2], ARADDR[1:0]};

  assign last_beat = (cnt_q == len_q);

  assign AWREADY = (state == IDLE) & init_done;
  assign ARREADY = (state == IDLE) & init_done & ~AWVALID;
  assign WREADY  = (state == W_DATA);
  assign RVALID  = (state == R_DATA);
  assign BVALID  = (state == W_RESP);

  assign aw_hs = AWVALID & AWREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign w_hs  = WVALID & WREADY;
  assign r_hs  = RVALID & RREADY;
  assign b_hs  = BVALID & BREADY;

  // DO only changes on an SRAM read, and the SRAM is idle in R_DATA, so
  // RDATA is stable across an R stall without a holding register.
  assign RDATA = DO;
  assign RID   = id_q;
  assign RRESP = RESP_OKAY;
  assign RLAST = RVALID & last_beat;
  assign BID   = id_q;
  assign BRESP = err_q ? RESP_SLVERR : RESP_OKAY;

  // Writes go to the SRAM in the same cycle as the W handshake.
  assign CEB = ~((state == R_SRAM) | w_hs);
  assign WEB = ~w_hs;
  assign A   = addr_q;
  assign DI  = w_hs ? WDATA : '0;

  always_comb begin
    BWEB = '1;
    if (w_hs) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        BWEB[8*i +: 8] = {8{~WSTRB[i]}};
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      init_done <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      init_done <= 1'b1;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q   <= AWID;
            len_q  <= AWLEN;
            addr_q <= AWADDR[SRAM_AW+1:2];
            cnt_q  <= '0;
            err_q  <= 1'b0;
            state  <= W_DATA;
          end else if (ar_hs) begin
            id_q   <= ARID;
            len_q  <= ARLEN;
            addr_q <= ARADDR[SRAM_AW+1:2];
            cnt_q  <= '0;
            state  <= R_SRAM;
          end
        end
        R_SRAM: state <= R_DATA;
        R_DATA: begin
          if (r_hs) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              cnt_q  <= cnt_q + 4'd1;
              addr_q <= addr_q + SRAM_AW'(1);
              state  <= R_SRAM;
            end
          end
        end
        W_DATA: begin
          if (w_hs) begin
            addr_q <= addr_q + SRAM_AW'(1);
            // A WLAST that disagrees with the beat count taints the response
            // but never shortens or extends the burst.
            if (WLAST != last_beat) err_q <= 1'b1;
            if (last_beat) state <= W_RESP;
            else           cnt_q <= cnt_q + 4'd1;
          end
        end
        W_RESP: if (b_hs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
module tb_sram_axi_slave;

  logic        ACLK;
  logic        ARESETn;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        CEB;
  logic        WEB;
  logic [31:0] BWEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] DO;

  sram_axi_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // SRAM model with a backdoor preload port
  logic [31:0] mem [0:16383];
  logic        bd_we;
  logic [13:0] bd_addr;
  logic [31:0] bd_data;

  always @(posedge ACLK) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (!CEB) begin
      if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
      else      DO <= mem[A];
    end
  end

  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge ACLK); #1 bd_we = 1'b0;
  endtask

  // All handshake tasks start and end one time unit after a rising edge.
  task automatic ar_send(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
    int n;
    ARADDR = addr; ARLEN = len; ARID = id; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    check("arready_seen", ARREADY, 1);
    @(posedge ACLK); #1 ARVALID = 1'b0;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [3:0] len, input logic [7:0] id);
    int n;
    AWADDR = addr; AWLEN = len; AWID = id; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    check("awready_seen", AWREADY, 1);
    @(posedge ACLK); #1 AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n;
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    check("wready_seen", WREADY, 1);
    check("sram_write_strobe", {CEB, WEB}, 2'b00);
    @(posedge ACLK); #1 WVALID = 1'b0;
  endtask

  // Ends on a falling edge with the cycle count since the previous rising edge.
  task automatic wait_rvalid(output int lat);
    lat = 0;
    do begin @(negedge ACLK); lat++; end while (!RVALID && lat < 50);
  endtask

  task automatic wait_bvalid(output int lat);
    lat = 0;
    do begin @(negedge ACLK); lat++; end while (!BVALID && lat < 50);
  endtask

  task automatic r_accept();
    RREADY = 1'b1;
    @(posedge ACLK); #1 RREADY = 1'b0;
  endtask

  task automatic b_accept();
    BREADY = 1'b1;
    @(posedge ACLK); #1 BREADY = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  id;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;   // read: expected RDATA; write: expected SRAM word afterwards
  } vec_t;

  vec_t vecs [11];

  initial begin
    int lat;
    n_pass = 0; n_total = 0;
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0; DO = '0;

    vecs[0]  = '{1'b0, 32'h0000_0040, 8'h05, 32'h0,         4'h0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h0000_0044, 8'h03, 32'h11223344,  4'b0101, 32'hAA22CC44};
    vecs[2]  = '{1'b0, 32'h0000_0044, 8'h07, 32'h0,         4'h0, 32'hAA22CC44};
    vecs[3]  = '{1'b1, 32'h0000_0080, 8'h01, 32'hCAFEF00D,  4'b1111, 32'hCAFEF00D};
    vecs[4]  = '{1'b0, 32'h0000_0080, 8'h02, 32'h0,         4'h0, 32'hCAFEF00D};
    vecs[5]  = '{1'b1, 32'h0000_0080, 8'h11, 32'h12345678,  4'b1000, 32'h12FEF00D};
    vecs[6]  = '{1'b0, 32'h0000_0080, 8'hFF, 32'h0,         4'h0, 32'h12FEF00D};
    vecs[7]  = '{1'b1, 32'h0000_0084, 8'h22, 32'hFFFFFFFF,  4'b0000, 32'h55555555};
    vecs[8]  = '{1'b0, 32'h0000_0084, 8'h33, 32'h0,         4'h0, 32'h55555555};
    vecs[9]  = '{1'b0, 32'hFFFF_0040, 8'h44, 32'h0,         4'h0, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 32'h0000_0042, 8'h55, 32'h0,         4'h0, 32'hDEADBEEF};

    // Reset values, before any clock edge
    #1;
    check("rst_awready", AWREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_wready",  WREADY, 0);
    check("rst_rvalid",  RVALID, 0);
    check("rst_bvalid",  BVALID, 0);
    check("rst_ceb",     CEB, 1);
    check("rst_web",     WEB, 1);
    check("rst_bweb",    BWEB, 32'hFFFFFFFF);
    check("rst_a",       A, 0);
    check("rst_di",      DI, 0);

    preload(14'h0010, 32'hDEADBEEF);
    preload(14'h0011, 32'hAABBCCDD);
    preload(14'h0021, 32'h55555555);
    for (int i = 0; i < 4; i++) preload(14'h0040 + 14'(i), 32'hA000_0000 + 32'(i));
    preload(14'h0080, 32'h0BADF00D);
    for (int i = 0; i < 4; i++) preload(14'h0100 + 14'(i), 32'hEEEEEEEE);

    ARESETn = 1'b1;
    @(negedge ACLK);
    check("init_awready_low", AWREADY, 0);
    @(negedge ACLK);
    check("init_awready_high", AWREADY, 1);
    @(posedge ACLK); #1;

    // Single-beat table
    for (int v = 0; v < 11; v++) begin
      if (vecs[v].wr) begin
        aw_send(vecs[v].addr, 4'd0, vecs[v].id);
        w_beat(vecs[v].wdata, vecs[v].wstrb, 1'b1);
        wait_bvalid(lat);
        check($sformatf("v%0d_b_latency", v), 64'(lat), 1);
        check($sformatf("v%0d_bresp", v), BRESP, 2'b00);
        check($sformatf("v%0d_bid", v), BID, vecs[v].id);
        b_accept();
        check($sformatf("v%0d_mem", v), mem[vecs[v].addr[15:2]], vecs[v].exp);
      end else begin
        ar_send(vecs[v].addr, 4'd0, vecs[v].id);
        wait_rvalid(lat);
        check($sformatf("v%0d_r_latency", v), 64'(lat), 2);
        check($sformatf("v%0d_rdata", v), RDATA, vecs[v].exp);
        check($sformatf("v%0d_rid", v), RID, vecs[v].id);
        check($sformatf("v%0d_rlast", v), RLAST, 1);
        check($sformatf("v%0d_rresp", v), RRESP, 2'b00);
        r_accept();
      end
    end

    // Four-beat read burst with a three-cycle stall on beat 1
    ar_send(32'h0000_0100, 4'd3, 8'h09);
    for (int b = 0; b < 4; b++) begin
      wait_rvalid(lat);
      check($sformatf("burst_b%0d_latency", b), 64'(lat), 2);
      check($sformatf("burst_b%0d_rdata", b), RDATA, 32'hA000_0000 + 32'(b));
      check($sformatf("burst_b%0d_rlast", b), RLAST, (b == 3) ? 1 : 0);
      check($sformatf("burst_b%0d_rid", b), RID, 8'h09);
      if (b == 1) begin
        repeat (3) begin
          @(negedge ACLK);
          check("stall_rvalid", RVALID, 1);
          check("stall_rdata", RDATA, 32'hA000_0001);
          check("stall_ceb", CEB, 1);
        end
      end
      r_accept();
    end

    // AW and AR together on the same address: write first, read sees new data
    AWADDR = 32'h200; AWLEN = 4'd0; AWID = 8'h0A; AWVALID = 1'b1;
    ARADDR = 32'h200; ARLEN = 4'd0; ARID = 8'h0B; ARVALID = 1'b1;
    @(negedge ACLK);
    check("tie_awready", AWREADY, 1);
    check("tie_arready", ARREADY, 0);
    @(posedge ACLK); #1 AWVALID = 1'b0;
    @(negedge ACLK);
    check("tie_arready_wdata", ARREADY, 0);
    @(posedge ACLK); #1;
    w_beat(32'h600DCAFE, 4'hF, 1'b1);
    wait_bvalid(lat);
    check("tie_b_latency", 64'(lat), 1);
    check("tie_arready_bresp", ARREADY, 0);
    check("tie_bid", BID, 8'h0A);
    b_accept();
    begin
      int n;
      n = 0;
      @(negedge ACLK);
      while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
      check("tie_arready_after_b", ARREADY, 1);
      @(posedge ACLK); #1 ARVALID = 1'b0;
    end
    wait_rvalid(lat);
    check("tie_r_latency", 64'(lat), 2);
    check("tie_rdata", RDATA, 32'h600DCAFE);
    check("tie_rid", RID, 8'h0B);
    r_accept();

    // WLAST early on a two-beat write
    aw_send(32'h300, 4'd1, 8'h0C);
    w_beat(32'h0000_0001, 4'hF, 1'b1);
    w_beat(32'h0000_0002, 4'hF, 1'b1);
    wait_bvalid(lat);
    check("wlast_b_latency", 64'(lat), 1);
    check("wlast_bresp", BRESP, 2'b10);
    b_accept();
    check("wlast_mem0", mem[14'h00C0], 32'h0000_0001);
    check("wlast_mem1", mem[14'h00C1], 32'h0000_0002);

    // Burst crossing the top of the SRAM
    aw_send(32'h0000_FFFC, 4'd1, 8'h0D);
    w_beat(32'h77777777, 4'hF, 1'b0);
    w_beat(32'h88888888, 4'hF, 1'b1);
    wait_bvalid(lat);
    check("wrap_bresp", BRESP, 2'b00);
    b_accept();
    check("wrap_mem_top", mem[14'h3FFF], 32'h77777777);
    check("wrap_mem_zero", mem[14'h0000], 32'h88888888);
    ar_send(32'h0000_FFFC, 4'd1, 8'h0E);
    wait_rvalid(lat);
    check("wrap_r0", RDATA, 32'h77777777);
    check("wrap_r0_last", RLAST, 0);
    r_accept();
    wait_rvalid(lat);
    check("wrap_r1", RDATA, 32'h88888888);
    check("wrap_r1_last", RLAST, 1);
    r_accept();

    // Reset pulse while beat 2 of a four-beat write is offered
    aw_send(32'h400, 4'd3, 8'h0F);
    w_beat(32'h0000_00B0, 4'hF, 1'b0);
    w_beat(32'h0000_00B1, 4'hF, 1'b0);
    WDATA = 32'h0000_00B2; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    #2 ARESETn = 1'b0;
    #1;
    check("mid_rst_wready",  WREADY, 0);
    check("mid_rst_ceb",     CEB, 1);
    check("mid_rst_web",     WEB, 1);
    check("mid_rst_bweb",    BWEB, 32'hFFFFFFFF);
    check("mid_rst_a",       A, 0);
    check("mid_rst_di",      DI, 0);
    check("mid_rst_awready", AWREADY, 0);
    check("mid_rst_bvalid",  BVALID, 0);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("post_rst_awready_low", AWREADY, 0);
    @(negedge ACLK);
    check("post_rst_awready_high", AWREADY, 1);
    check("post_rst_bvalid", BVALID, 0);
    check("post_rst_mem0", mem[14'h0100], 32'h0000_00B0);
    check("post_rst_mem1", mem[14'h0101], 32'h0000_00B1);
    check("post_rst_mem2", mem[14'h0102], 32'hEEEEEEEE);
    check("post_rst_mem3", mem[14'h0103], 32'hEEEEEEEE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_axi_slave.md
# sram_axi_slave

AXI4 responder that sits between the AXI interconnect and one 32-bit synchronous SRAM macro (instruction or data memory). It is the memory-side counterpart to the CPU master: it accepts the loads and stores issued by the core's memory stage and turns them into SRAM cycles. It supports single and INCR bursts with byte strobes, and returns read data and write responses with full AXI valid/ready handshaking.

## Interface
- `ID_W`, default 8: AXI ID width on the slave side.
- `ADDR_W`, default 32: AXI address width.
- `DATA_W`, default 32: data width; fixed at 32, no other value supported.
- `SRAM_AW`, default 14: SRAM word-address width (16K words).
- `ACLK` in 1: the single clock.
- `ARESETn` in 1: asynchronous, active-low reset.
- `AWID` in ID_W, `AWADDR` in ADDR_W, `AWLEN` in 4, `AWSIZE` in 3, `AWBURST` in 2, `AWVALID` in 1, `AWREADY` out 1: write address channel.
- `WDATA` in 32, `WSTRB` in 4, `WLAST` in 1, `WVALID` in 1, `WREADY` out 1: write data channel.
- `BID` out ID_W, `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response channel.
- `ARID` in ID_W, `ARADDR` in ADDR_W, `ARLEN` in 4, `ARSIZE` in 3, `ARBURST` in 2, `ARVALID` in 1, `ARREADY` out 1: read address channel.
- `RID` out ID_W, `RDATA` out 32, `RRESP` out 2, `RLAST` out 1, `RVALID` out 1, `RREADY` in 1: read data channel.
- `CEB` out 1: SRAM chip enable, active-low.
- `WEB` out 1: SRAM write enable, active-low (0 means write).
- `BWEB` out 32: SRAM per-bit write enable, active-low.
- `A` out SRAM_AW: SRAM word address.
- `DI` out 32: SRAM write data.
- `DO` in 32: SRAM read data. It is valid the cycle after a read edge and holds until the next access.

## Operation
- States: `IDLE`, `R_SRAM`, `R_DATA`, `W_DATA`, `W_RESP`.
- In `IDLE`:
  - `AWREADY` = `init_done`.
  - `ARREADY` = `init_done & ~AWVALID`, so a write wins when AW and AR are valid in the same cycle.
  - `init_done` resets to 0 and sets on the first `ACLK` edge after reset deasserts.
- Capture on handshake: ID, LEN, and word address `addr[SRAM_AW+1:2]`. Set the beat counter to 0.
- AR handshake goes to `R_SRAM`.
  - `R_SRAM`: `CEB`=0, `WEB`=1, `A`=current address, then go to `R_DATA`.
  - `R_DATA`: `RVALID`=1, `RDATA`=`DO`, `RID`=captured ID, `RRESP`=OKAY, `RLAST`=(cnt==LEN).
  - On `RVALID&RREADY`: if last beat, go to `IDLE`. Otherwise increment cnt and address, then go to `R_SRAM`.
- AW handshake goes to `W_DATA`.
  - `W_DATA`: `WREADY`=1.
  - On `WVALID&WREADY`: `CEB`=0, `WEB`=0, `A`=address, `DI`=`WDATA`. `BWEB[8i+7:8i]` = `{8{~WSTRB[i]}}`. Then increment the address.
  - When cnt==LEN, go to `W_RESP`. Otherwise increment cnt.
- `W_RESP`: `BVALID`=1, `BID`=captured ID. `BRESP` is OKAY, or SLVERR if any beat's `WLAST` disagreed with (cnt==LEN). Go to `IDLE` on `BREADY`.
- Width rules:
  - Address increments by one word and wraps modulo 2^SRAM_AW.
  - Address bits above `SRAM_AW+1` are ignored.
  - `*BURST` is ignored; every burst is treated as INCR.
  - `*SIZE` is ignored; `WSTRB` selects the bytes written.
- Outside the access cycles: `CEB`=1, `WEB`=1, `BWEB`=all ones.

## Timing
- Reset, async and immediate: state=`IDLE`, `init_done`=0. All READY and VALID outputs are 0. `CEB`=1, `WEB`=1, `BWEB`=all ones, `A`=0, `DI`=0. `RDATA` follows `DO` but is qualified only by `RVALID`=0.
- Reset asserted mid-burst: the burst is abandoned, nothing more is written, and no response is returned.
- Read latency: AR handshake at cycle t, SRAM read at t+1, `RVALID` at t+2. Each further beat takes 2 cycles after its R handshake.
- While `RVALID` is high and `RREADY` is low: `RDATA` stays stable because the SRAM is idle.
- Write: `WREADY` is high from cycle t+1 after the AW handshake. The SRAM write happens in the same cycle as the W handshake. `BVALID` comes 1 cycle after the last W handshake.
- VALID outputs never drop without a handshake.
- No outstanding transactions: the AW and AR READYs stay low until the response completes.

## Structure
- Shared package `axi_pkg`: `AXI_ID_W`, `AXI_ADDR_W`, and `AXI_DATA_W` constants; response encodings OKAY=2'b00 and SLVERR=2'b10; burst encodings; the `sram_slv_state_e` enum.
- A single module with no sub-module. The beat counter and address register are inline.

## Test plan
- Single read: SRAM word 0x10 = 0xDEADBEEF; ARADDR=0x40, ARLEN=0, ARID=5 -> `RVALID` at t+2 with `RDATA`=0xDEADBEEF, `RID`=5, `RLAST`=1, `RRESP`=0.
- Strobed write: AWADDR=0x44, WDATA=0x11223344, WSTRB=4'b0101 onto a word of 0xAABBCCDD -> word 0x11 reads 0xAA22CC44; `BRESP`=OKAY, with `BVALID` 1 cycle after the W handshake.
- Read burst with RREADY stalled: ARLEN=3 from 0x100 with `RREADY` low for 3 cycles on beat 1 -> 4 beats in address order; `RDATA` holds during the stall; `RLAST` only on beat 3.
- Simultaneous AW and AR to the same address in one cycle -> write accepted first, `ARREADY` 0 until after the B handshake; the read then returns the new data.
- WLAST mismatch: AWLEN=1 with `WLAST` set on beat 0 -> two beats written, `BRESP`=SLVERR. Address wrap: a burst starting at word 0x3FFF continues at word 0.
- Reset pulse during beat 2 of a 4-beat write -> all outputs go to their reset values immediately; beats 2-3 are unwritten; `AWREADY` returns 1 cycle after reset deasserts.
